serial_frame_tx: RTL
====================

# serial_frame_tx

Serial frame transmitter on the falling clock edge. It takes a parallel word on a `start` strobe and shifts it out on a single line as a framed sequence: start bit, data bits LSB first, optional even parity, then stop bit. It is the sending end for the team's negedge serial capture logic. On the board it sits between the switch inputs (`data`/`start`) and an LED/GPIO line (`tx`).

## Interface
- `DATA_W`, default 8: number of data bits per frame (legal range 1..16).
- `CLKS_PER_BIT`, default 4: clock cycles each bit is held on `tx` (legal range ≥1).

- `clock`  input  1  all state updates on the falling edge.
- `resetp`  input  1  reset: asynchronous, active-high.
- `start`  input  1  request to send; sampled on falling edge, honoured only when not busy.
- `data`  input  DATA_W  word to send; captured on the accepted `start` edge.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  high while a frame is in progress.
- `done`  output  1  one-cycle pulse marking frame completion.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `tx`=1 and `busy`=0. On a falling edge with `start`=1:
  - capture `data` into the shift register;
  - go to START with `tx`=0 and `busy`=1;
  - clear the bit-period counter and bit index.
- Bit-period counter counts 0..CLKS_PER_BIT-1. The state or bit advances only on the edge where the counter equals CLKS_PER_BIT-1, and the counter wraps to 0 on that edge.
- START: holds 0 for one bit period, then goes to DATA with `tx`=shreg[0].
- DATA: sends bits index 0..DATA_W-1, LSB first, one bit period each.
  - After bit DATA_W-1, go to PARITY if it is compiled in, otherwise STOP.
  - The bit index counter is wide enough to hold DATA_W-1.
- PARITY: `tx` = XOR of all captured data bits (even parity), held one bit period, then STOP.
- STOP: `tx`=1 for one bit period. On its last edge:
  - go to IDLE;
  - `busy`=0;
  - `done`=1 for exactly one cycle.
- `start` while `busy`=1 is ignored. Changes on `data` after capture have no effect.
- A `start` sampled on the same edge that leaves STOP is ignored, because `busy` is still 1 when sampled. The earliest next accept is the following falling edge.
- `tx`, `busy` and `done` are registered outputs with no combinational path from inputs.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, state IDLE, counters 0, shift register 0.
- `resetp` mid-frame aborts immediately and asynchronously: `tx`→1 and `busy`→0, with no `done` pulse.
- Latency: `tx` falls on the same falling edge that accepts `start`.
- Frame length: F = (DATA_W + 2 + P) × CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- `done` rises F cycles after the accept edge and lasts one cycle. `busy` is high for exactly F cycles.
- Minimum start-to-start spacing for continuous `start`=1 is F+1 cycles, which gives one idle cycle with `tx`=1 between frames.
- CLKS_PER_BIT=1: every state lasts exactly one cycle, and the counter is constantly at its terminal value.

## Configuration
- `SERIAL_TX_PARITY_EN` defined: the PARITY state and even-parity bit are compiled in, and P=1.
- `SERIAL_TX_PARITY_EN` undefined: PARITY state and parity logic are absent. DATA goes straight to STOP, and P=0.

## Test plan
All scenarios use DATA_W=8 and CLKS_PER_BIT=4 unless stated otherwise.

- **Reset:** `resetp`=1 with `clock` stopped → `tx`=1, `busy`=0, `done`=0 with no clock edge needed.
- **No parity, 0xA5:** pulse `start` → `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `busy`=1 for 40 cycles, and `done` pulses at cycle 40.
- **With `SERIAL_TX_PARITY_EN`, 0x07:**
  - sequence 0,1,1,1,0,0,0,0,0, then parity 1, then stop 1;
  - 44 cycles, `done` at cycle 44;
  - 0x03 gives parity 0.
- **Start while busy:** pulse `start` with 0xFF during data bit 2 of a 0x00 frame → frame stays 0x00 and there is exactly one `done` pulse.
- **Reset mid-frame:** assert `resetp` during data bit 3 → `tx`=1 and `busy`=0 asynchronously, with no `done`. A following `start` with 0x3C sends a complete, correct frame.
- **Back-to-back, CLKS_PER_BIT=1:** hold `start`=1 with 0x55 → frames of 10 cycles separated by exactly one idle cycle with `tx`=1. `done` pulses every 11 cycles.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Falling-edge serial frame transmitter: start bit, DATA_W data bits LSB first,
// optional even parity (define SERIAL_TX_PARITY_EN), stop bit.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clock,
    input  logic              resetp,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic              tx_d, busy_d, done_d;
    logic              last;

    always_ff @(negedge clock or posedge resetp) begin
        if (resetp) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shreg <= shreg_d;
            tx    <= tx_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    assign last = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Outputs are computed one edge ahead so tx/busy/done stay pure registers.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shreg_d = shreg;
        tx_d    = tx;
        busy_d  = busy;
        done_d  = 1'b0;

        if (state != IDLE)
            cnt_d = last ? '0 : cnt + 1'b1;

        case (state)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    shreg_d = data;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (last) begin
                    state_d = DATA;
                    tx_d    = shreg[0];
                end
            end
            DATA: begin
                if (last) begin
                    if (idx == IDX_W'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^shreg;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx + 1'b1;
                        tx_d  = shreg[idx + 1'b1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (last) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (last) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
